// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
//   master : drives start, a, b, cin; observes busy, done, sum, cout
//   slave  : the adder itself (consumes the request, produces the result)
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell processes one bit pair per
// clock, LSB first, with a carry flip-flop feeding cout back into cin.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (aborts any operation in flight)
//   bus  serial_adder_if.slave:
//          start      request, sampled only in IDLE
//          a, b, cin  operands, captured when start is accepted
//          busy       high while bits are being processed
//          done       one-cycle pulse when sum/cout are final
//          sum, cout  result, held from done until the next accepted start
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int                CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  sum_r;
    logic              carry;
    logic              cout_r;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        fa;
    logic              last_bit;
    logic              busy_c;
    logic              done_c;

    // The full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
        return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
    endfunction

    assign fa       = full_adder(a_sh[0], b_sh[0], carry);
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state == RUN);
        done_c = (state == DONE);
    end

    // Datapath: capture on accepted start, one bit per edge while running.
    // The counter stops at LAST rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else if (state == IDLE && bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            carry  <= bus.cin;
            sum_r  <= '0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            sum_r <= {fa[0], sum_r[WIDTH-1:1]};
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            carry <= fa[1];
            if (last_bit) begin
                cout_r <= fa[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
endmodule
